// File: rtl/add_pipe.sv
// add_pipe: pipelined add/subtract unit with a valid/ready handshake.
// A WIDTH-bit operation is cut into STAGES segments of SEG bits. Each pipeline
// stage resolves one segment and registers its carry for the next stage.
// Optional feature macro: ADD_PIPE_SAT_EN adds a per-beat 'sat' input that
// clamps overflowed results to the most positive or most negative value.
module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef ADD_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage state: skewed operand copies, partial sum, segment carry,
    // beat valid and the saturation request that travels with the beat.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             vld_q [STAGES];
    logic             sat_q [STAGES];

    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_d   [STAGES];
    logic             vld_d [STAGES];
    logic             sat_d [STAGES];

    logic             sat_i;
    logic             adv;

    logic [WIDTH-1:0] pa, pb, ps;
    logic             pc, pv, psat;
    logic [SEG:0]     seg;

    logic [WIDTH-1:0] res;
    logic             a_msb, b_msb, ovf_raw;

`ifdef ADD_PIPE_SAT_EN
    assign sat_i = sat;
`else
    assign sat_i = 1'b0;
`endif

    // Clamp value for an overflowed result: the true result takes the sign of
    // the operands, so a negative operand pair saturates to the most negative.
    function automatic logic [WIDTH-1:0] sat_clamp(input logic neg);
        logic signed [WIDTH-1:0] lim;
        lim = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return lim;
    endfunction

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv       = !vld_q[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];

    // Next-state for every stage: stage k adds segment k of the operands it
    // holds plus the carry produced by the stage before it.
    always_comb begin
        pa   = a;
        pb   = sub ? ~b : b;
        pc   = sub ? 1'b1 : cin;
        ps   = '0;
        pv   = in_valid;
        psat = sat_i;
        seg  = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg = {1'b0, pa[k*SEG +: SEG]} + {1'b0, pb[k*SEG +: SEG]} + {{SEG{1'b0}}, pc};
            ps[k*SEG +: SEG] = seg[SEG-1:0];
            a_d[k]   = pa;
            b_d[k]   = pb;
            s_d[k]   = ps;
            c_d[k]   = seg[SEG];
            vld_d[k] = pv;
            sat_d[k] = psat;
            if (k < STAGES - 1) begin
                pa   = a_q[k];
                pb   = b_q[k];
                pc   = c_q[k];
                ps   = s_q[k];
                pv   = vld_q[k];
                psat = sat_q[k];
            end
        end
    end

    // Stage registers: cleared on reset so no beat survives it, held on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                vld_q[k] <= 1'b0;
                sat_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                vld_q[k] <= vld_d[k];
                sat_q[k] <= sat_d[k];
            end
        end
    end

    // Result and flags from the last stage; zero is qualified by valid so the
    // flag reads 0 out of reset.
    always_comb begin
        res     = s_q[LAST];
        a_msb   = a_q[LAST][WIDTH-1];
        b_msb   = b_q[LAST][WIDTH-1];
        ovf_raw = (a_msb == b_msb) && (res[WIDTH-1] != a_msb);
        out     = res;
        if (sat_q[LAST] && ovf_raw) begin
            out = sat_clamp(a_msb);
        end
        carry = c_q[LAST];
        ovf   = ovf_raw;
        zero  = vld_q[LAST] && (out == '0);
    end

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed and randomised checks of add_pipe at STAGES=1, 2, 4.
// All three instances share the input side; the STAGES=2 instance carries the
// directed scenarios and every instance is checked in the random stream.
module tb_add_pipe;

    logic        clk, rst, in_valid, cin, sub, sat, out_ready;
    logic [31:0] a, b;

    logic [31:0] d_out    [3];
    logic        d_carry  [3];
    logic        d_ovf    [3];
    logic        d_zero   [3];
    logic        d_ovalid [3];
    logic        d_iready [3];

    int tests;
    int fails;

    add_pipe #(.WIDTH(32), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_iready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef ADD_PIPE_SAT_EN
        .sat(sat),
`endif
        .out_valid(d_ovalid[0]), .out_ready(out_ready), .out(d_out[0]),
        .carry(d_carry[0]), .ovf(d_ovf[0]), .zero(d_zero[0])
    );

    add_pipe #(.WIDTH(32), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_iready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef ADD_PIPE_SAT_EN
        .sat(sat),
`endif
        .out_valid(d_ovalid[1]), .out_ready(out_ready), .out(d_out[1]),
        .carry(d_carry[1]), .ovf(d_ovf[1]), .zero(d_zero[1])
    );

    add_pipe #(.WIDTH(32), .STAGES(4)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_iready[2]),
        .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef ADD_PIPE_SAT_EN
        .sat(sat),
`endif
        .out_valid(d_ovalid[2]), .out_ready(out_ready), .out(d_out[2]),
        .carry(d_carry[2]), .ovf(d_ovf[2]), .zero(d_zero[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {zero, ovf, carry, out} from a single full-width addition.
    function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mcin, input logic msub, input logic msat);
        logic [31:0] be, r;
        logic [32:0] s;
        logic        o;
        be = msub ? ~mb : mb;
        s  = {1'b0, ma} + {1'b0, be} + {32'd0, (msub ? 1'b1 : mcin)};
        o  = (ma[31] == be[31]) && (s[31] != ma[31]);
        r  = s[31:0];
        if (msat && o) r = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {(r == 32'd0), o, s[32], r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic tsub, input logic tcin, input logic tsat);
        a = ta; b = tb_v; sub = tsub; cin = tcin; sat = tsat; in_valid = 1'b1;
    endtask

    // One beat through the STAGES=2 instance; result is visible on return.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tsub, input logic tcin, input logic tsat);
        out_ready = 1'b1;
        set_beat(ta, tb_v, tsub, tcin, tsat);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (d_ovalid[1] !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", d_ovalid[1]); end
        tests++; if (d_iready[1] !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", d_iready[1]); end
        tests++; if (d_out[1] !== 32'd0) begin fails++; $display("FAIL reset_out: got %h want 0", d_out[1]); end
        tests++; if (d_carry[1] !== 1'b0) begin fails++; $display("FAIL reset_carry: got %b want 0", d_carry[1]); end
        tests++; if (d_ovf[1] !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", d_ovf[1]); end
        tests++; if (d_zero[1] !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b want 0", d_zero[1]); end
        tests++; if (d_ovalid[0] !== 1'b0 || d_ovalid[2] !== 1'b0) begin
            fails++; $display("FAIL reset_other_valid: got %b%b want 00", d_ovalid[0], d_ovalid[2]); end
        rst = 1'b0;
        tick();
        tests++; if (d_ovalid[1] !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b want 0", d_ovalid[1]); end
    endtask

    task automatic test_carry_seg();
        out_ready = 1'b1;
        set_beat(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++; if (d_ovalid[1] !== 1'b0) begin fails++; $display("FAIL carry_latency_early: got %b want 0", d_ovalid[1]); end
        tick();
        tests++; if (d_ovalid[1] !== 1'b1) begin fails++; $display("FAIL carry_latency: got %b want 1", d_ovalid[1]); end
        tests++; if (d_out[1] !== 32'h0001_0000) begin fails++; $display("FAIL carry_out: got %h want 00010000", d_out[1]); end
        tests++; if ({d_carry[1], d_ovf[1], d_zero[1]} !== 3'b000) begin
            fails++; $display("FAIL carry_flags: got c%b v%b z%b want 000", d_carry[1], d_ovf[1], d_zero[1]); end
    endtask

    task automatic test_subtract();
        send(32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
        tests++; if (d_out[1] !== 32'd0 || {d_carry[1], d_ovf[1], d_zero[1]} !== 3'b101) begin
            fails++; $display("FAIL sub_equal: got %h c%b v%b z%b want 0 c1 v0 z1", d_out[1], d_carry[1], d_ovf[1], d_zero[1]); end
        send(32'd5, 32'd5, 1'b1, 1'b1, 1'b0);
        tests++; if (d_out[1] !== 32'd0 || d_zero[1] !== 1'b1) begin
            fails++; $display("FAIL sub_cin_ignored: got %h z%b want 0 z1", d_out[1], d_zero[1]); end
        send(32'd0, 32'd1, 1'b1, 1'b0, 1'b0);
        tests++; if (d_out[1] !== 32'hFFFF_FFFF || {d_carry[1], d_ovf[1], d_zero[1]} !== 3'b000) begin
            fails++; $display("FAIL sub_borrow: got %h c%b v%b z%b want ffffffff c0 v0 z0", d_out[1], d_carry[1], d_ovf[1], d_zero[1]); end
        send(32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
        tests++; if (d_out[1] !== 32'd4 || d_carry[1] !== 1'b0) begin
            fails++; $display("FAIL add_cin: got %h c%b want 4 c0", d_out[1], d_carry[1]); end
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        tests++; if (d_out[1] !== 32'd0 || {d_carry[1], d_ovf[1], d_zero[1]} !== 3'b101) begin
            fails++; $display("FAIL add_wrap: got %h c%b v%b z%b want 0 c1 v0 z1", d_out[1], d_carry[1], d_ovf[1], d_zero[1]); end
    endtask

    task automatic test_overflow();
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        tests++; if (d_out[1] !== 32'h8000_0000 || {d_carry[1], d_ovf[1], d_zero[1]} !== 3'b010) begin
            fails++; $display("FAIL ovf_pos: got %h c%b v%b z%b want 80000000 c0 v1 z0", d_out[1], d_carry[1], d_ovf[1], d_zero[1]); end
        send(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b0);
        tests++; if (d_out[1] !== 32'h7FFF_FFFF || {d_carry[1], d_ovf[1]} !== 2'b11) begin
            fails++; $display("FAIL ovf_sub_neg: got %h c%b v%b want 7fffffff c1 v1", d_out[1], d_carry[1], d_ovf[1]); end
`ifdef ADD_PIPE_SAT_EN
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
        tests++; if (d_out[1] !== 32'h7FFF_FFFF || {d_carry[1], d_ovf[1], d_zero[1]} !== 3'b010) begin
            fails++; $display("FAIL sat_pos: got %h c%b v%b z%b want 7fffffff c0 v1 z0", d_out[1], d_carry[1], d_ovf[1], d_zero[1]); end
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        tests++; if (d_out[1] !== 32'h8000_0000 || {d_carry[1], d_ovf[1]} !== 2'b11) begin
            fails++; $display("FAIL sat_neg: got %h c%b v%b want 80000000 c1 v1", d_out[1], d_carry[1], d_ovf[1]); end
        send(32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        tests++; if (d_out[1] !== 32'd3 || d_ovf[1] !== 1'b0) begin
            fails++; $display("FAIL sat_no_ovf: got %h v%b want 3 v0", d_out[1], d_ovf[1]); end
`endif
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        set_beat(32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
        tick();
        set_beat(32'h33, 32'h44, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++; if (d_ovalid[1] !== 1'b1) begin fails++; $display("FAIL mid_inflight: got %b want 1", d_ovalid[1]); end
        rst = 1'b1;
        #1;
        tests++; if (d_ovalid[1] !== 1'b0 || d_out[1] !== 32'd0) begin
            fails++; $display("FAIL mid_async_clear: got v%b out %h want v0 out 0", d_ovalid[1], d_out[1]); end
        tick();
        tests++; if (d_ovalid[1] !== 1'b0 || d_out[1] !== 32'd0 || d_iready[1] !== 1'b1) begin
            fails++; $display("FAIL mid_reset_edge: got v%b out %h rdy %b want v0 out 0 rdy1", d_ovalid[1], d_out[1], d_iready[1]); end
        rst = 1'b0;
        out_ready = 1'b1;
        begin
            int stale;
            stale = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (d_ovalid[0] !== 1'b0 || d_ovalid[1] !== 1'b0 || d_ovalid[2] !== 1'b0) stale++;
            end
            tests++; if (stale != 0) begin fails++; $display("FAIL mid_stale_beat: got %0d valid cycles want 0", stale); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ba [10];
        logic [31:0] bb [10];
        logic        bs [10];
        logic [34:0] exp_v;
        logic [31:0] held_val;
        logic        held;
        int tx, rx, cyc, extra;
        for (int i = 0; i < 10; i++) begin
            ba[i] = 32'h0000_FFF8 + i * 32'h0102_0304;
            bb[i] = 32'h10 + i;
            bs[i] = (i % 3 == 2);
        end
        tx = 0; rx = 0; cyc = 0; held = 1'b0; held_val = '0;
        while (cyc < 40 && rx < 10) begin
            in_valid = (tx < 10);
            if (tx < 10) begin a = ba[tx]; b = bb[tx]; sub = bs[tx]; cin = 1'b0; sat = 1'b0; end
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (!out_ready && d_ovalid[1] === 1'b1) begin
                tests++; if (d_iready[1] !== 1'b0) begin fails++; $display("FAIL b2b_stall_ready: cyc %0d got %b want 0", cyc, d_iready[1]); end
                if (held) begin
                    tests++; if (d_out[1] !== held_val) begin fails++; $display("FAIL b2b_hold: cyc %0d got %h want %h", cyc, d_out[1], held_val); end
                end
                held = 1'b1; held_val = d_out[1];
            end else begin
                held = 1'b0;
            end
            if (d_ovalid[1] === 1'b1 && out_ready) begin
                exp_v = model(ba[rx], bb[rx], 1'b0, bs[rx], 1'b0);
                tests++; if ({d_zero[1], d_ovf[1], d_carry[1], d_out[1]} !== exp_v) begin
                    fails++; $display("FAIL b2b_result[%0d]: got %h want %h", rx, {d_zero[1], d_ovf[1], d_carry[1], d_out[1]}, exp_v); end
                rx++;
            end
            if (in_valid && d_iready[1] === 1'b1) tx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests++; if (rx != 10 || tx != 10) begin fails++; $display("FAIL b2b_count: got rx %0d tx %0d want 10 10", rx, tx); end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d_ovalid[1] === 1'b1) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL b2b_duplicate: got %0d extra beats want 0", extra); end
    endtask

    task automatic test_random();
        logic [31:0] ra [1100];
        logic [31:0] rb [1100];
        logic        rcn [1100];
        logic        rsb [1100];
        logic        rst_s [1100];
        int          rcyc [1100];
        int          rd [3];
        int          lat [3];
        logic [34:0] exp_v;
        int n;
        lat[0] = 1; lat[1] = 2; lat[2] = 4;
        rd[0] = 0; rd[1] = 0; rd[2] = 0;
        n = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int cyc = 0; cyc < 1010; cyc++) begin
            if (cyc < 1000) begin
                in_valid = ($urandom_range(0, 4) != 0);
                a   = $urandom;
                b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
                cin = $urandom_range(0, 1);
                sub = $urandom_range(0, 1);
`ifdef ADD_PIPE_SAT_EN
                sat = $urandom_range(0, 1);
`else
                sat = 1'b0;
`endif
            end else begin
                in_valid = 1'b0;
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                if (d_ovalid[d] === 1'b1) begin
                    if (rd[d] >= n) begin
                        tests++; fails++;
                        $display("FAIL rand_unexpected[%0d]: got beat at cyc %0d want none", lat[d], cyc);
                    end else begin
                        exp_v = model(ra[rd[d]], rb[rd[d]], rcn[rd[d]], rsb[rd[d]], rst_s[rd[d]]);
                        tests++; if ({d_zero[d], d_ovf[d], d_carry[d], d_out[d]} !== exp_v) begin
                            fails++; $display("FAIL rand_result[S%0d #%0d]: got %h want %h", lat[d], rd[d], {d_zero[d], d_ovf[d], d_carry[d], d_out[d]}, exp_v); end
                        tests++; if (cyc - rcyc[rd[d]] != lat[d]) begin
                            fails++; $display("FAIL rand_latency[S%0d #%0d]: got %0d want %0d", lat[d], rd[d], cyc - rcyc[rd[d]], lat[d]); end
                        rd[d]++;
                    end
                end
            end
            if (in_valid) begin
                ra[n] = a; rb[n] = b; rcn[n] = cin; rsb[n] = sub; rst_s[n] = sat; rcyc[n] = cyc;
                n++;
            end
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            tests++; if (rd[d] != n) begin fails++; $display("FAIL rand_drained[S%0d]: got %0d want %0d", lat[d], rd[d], n); end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
        test_reset();
        test_carry_seg();
        test_subtract();
        test_overflow();
        test_reset_midstream();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
